// File: rtl/if_fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_fetch_stage_pkg;

  localparam int PC_W = 32;
  localparam logic [31:0] NOP_ENC = 32'h0000_0013;  // addi x0,x0,0

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_e;

  // Redirect targets are forced onto a word boundary.
  function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] addr);
    return {addr[PC_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues one outstanding imem request
// at a time, presents the fetched instruction to IF/ID and inserts a NOP
// bubble whenever no valid instruction is available.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0]     NOP_INSTR = NOP_ENC
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            PC_write,
  input  logic            PCSrc,
  input  logic [PC_W-1:0] PC_Branch,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic [PC_W-1:0] PC_IF,
  output logic [31:0]     INSTRUCTION_IF,
  output logic            IF_valid
);

  fetch_state_e    state, state_nxt;
  logic [PC_W-1:0] pc, pc_nxt;
  logic            drop, drop_nxt;
  logic [31:0]     hold_buf, hold_nxt;
  logic            resp_ok;

  // A response is usable only if it arrives in WAIT and was not invalidated by a redirect.
  assign resp_ok = (state == S_WAIT) && imem_rvalid && !drop;

  // Output decode: a redirect suppresses presentation in the cycle it happens.
  always_comb begin
    imem_req       = (state == S_REQ);
    imem_addr      = pc;
    PC_IF          = pc;
    IF_valid       = !PCSrc && (resp_ok || (state == S_HOLD));
    INSTRUCTION_IF = NOP_INSTR;
    if (IF_valid)
      INSTRUCTION_IF = (state == S_HOLD) ? hold_buf : imem_rdata;
  end

  // Next-state logic: redirect first, then the normal request/wait/hold flow.
  always_comb begin
    // NOTE: every signal gets a default here so no path leaves it unassigned and infers a latch.
    state_nxt = state;
    pc_nxt    = pc;
    drop_nxt  = drop;
    hold_nxt  = hold_buf;
    if (PCSrc) begin
      pc_nxt = word_align(PC_Branch);
      unique case (state)
        S_REQ: begin
          // An old-PC request accepted this very cycle still owes a response; drop it.
          if (imem_ready) begin
            state_nxt = S_WAIT;
            drop_nxt  = 1'b1;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            state_nxt = S_REQ;
            drop_nxt  = 1'b0;
          end else begin
            drop_nxt  = 1'b1;
          end
        end
        S_HOLD: begin
          state_nxt = S_REQ;
          hold_nxt  = NOP_INSTR;
        end
        default: state_nxt = S_REQ;
      endcase
    end else begin
      unique case (state)
        S_REQ: begin
          if (imem_ready) state_nxt = S_WAIT;
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            if (drop) begin
              drop_nxt  = 1'b0;
              state_nxt = S_REQ;
            end else if (PC_write) begin
              pc_nxt    = pc + 32'd4;
              state_nxt = S_REQ;
            end else begin
              hold_nxt  = imem_rdata;
              state_nxt = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (PC_write) begin
            pc_nxt    = pc + 32'd4;
            state_nxt = S_REQ;
          end
        end
        default: state_nxt = S_REQ;
      endcase
    end
  end

  // State register; reset aborts any outstanding request immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_REQ;
      pc       <= RESET_PC;
      drop     <= 1'b0;
      // NOTE: the hold buffer is reset so a bubble is the only thing it can ever leak.
      hold_buf <= NOP_INSTR;
    end else begin
      // NOTE: non-blocking so all registers update from the same pre-edge values.
      state    <= state_nxt;
      pc       <= pc_nxt;
      drop     <= drop_nxt;
      hold_buf <= hold_nxt;
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage. A transaction-level model tracks
// the architectural PC, whether an instruction for it is available, and an
// epoch tag that marks responses issued before a redirect as stale.
module tb_if_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        PC_write, PCSrc;
  logic [31:0] PC_Branch;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready, imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] PC_IF, INSTRUCTION_IF;
  logic        IF_valid;

  if_fetch_stage #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
    .clk(clk), .reset(reset), .PC_write(PC_write), .PCSrc(PCSrc),
    .PC_Branch(PC_Branch), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .PC_IF(PC_IF), .INSTRUCTION_IF(INSTRUCTION_IF), .IF_valid(IF_valid)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_fail  = 0;

  // Reference model state.
  logic [31:0] exp_pc;
  bit          avail;        // instruction for exp_pc received and waiting
  int unsigned epoch;
  // Memory model: one outstanding request.
  bit          out_valid;
  logic [31:0] out_addr;
  int unsigned out_epoch;
  int          out_cnt;
  int          mem_lat;      // latency for the next accepted request
  bit          rand_lat;

  // Program contents as a function of address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic reset_model();
    exp_pc    = RST_PC;
    avail     = 1'b0;
    out_valid = 1'b0;
    epoch++;
  endtask

  // One clock cycle: present memory response, check outputs, advance model.
  task automatic cycle();
    bit          live, exp_req, exp_valid, acc;
    logic [31:0] acc_addr;
    imem_rvalid = out_valid && (out_cnt == 0);
    imem_rdata  = imem_rvalid ? mem_word(out_addr) : 32'hDEAD_BEEF;
    #1;
    live      = imem_rvalid && (out_epoch == epoch);
    exp_req   = !out_valid && !avail;
    exp_valid = !PCSrc && (avail || live);
    check("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
    if (exp_req) check("imem_addr", imem_addr, exp_pc);
    check("IF_valid", {31'b0, IF_valid}, {31'b0, exp_valid});
    check("INSTRUCTION_IF", INSTRUCTION_IF, exp_valid ? mem_word(exp_pc) : NOP);
    check("PC_IF", PC_IF, exp_pc);
    acc      = imem_req && imem_ready;
    acc_addr = imem_addr;
    @(posedge clk);
    if (imem_rvalid) out_valid = 1'b0;
    else if (out_valid) out_cnt--;
    if (acc) begin
      out_valid = 1'b1;
      out_addr  = acc_addr;
      out_epoch = epoch;
      out_cnt   = rand_lat ? int'($urandom_range(0, 2)) : mem_lat;
    end
    if (PCSrc) begin
      exp_pc = {PC_Branch[31:2], 2'b00};
      avail  = 1'b0;
      epoch++;
    end else if (exp_valid && PC_write) begin
      exp_pc = exp_pc + 32'd4;
      avail  = 1'b0;
    end else if (live) begin
      avail = 1'b1;
    end
    @(negedge clk);
  endtask

  // Cycle until a request is visible, bounded.
  task automatic run_until_req(input int max_cycles);
    for (int i = 0; i < max_cycles && !imem_req; i++) cycle();
    check("req_seen", {31'b0, imem_req}, 32'd1);
  endtask

  initial begin
    reset = 1'b1; PC_write = 1'b0; PCSrc = 1'b0; PC_Branch = '0;
    imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    epoch = 0; mem_lat = 0; rand_lat = 1'b0; out_cnt = 0; out_epoch = 0; out_addr = '0;
    reset_model();

    // Reset values.
    @(negedge clk); @(negedge clk);
    check("rst_req",   {31'b0, imem_req}, 32'd1);
    check("rst_addr",  imem_addr, RST_PC);
    check("rst_valid", {31'b0, IF_valid}, 32'd0);
    check("rst_instr", INSTRUCTION_IF, NOP);
    check("rst_pc_if", PC_IF, RST_PC);
    reset = 1'b0;
    reset_model();

    // Zero-wait memory, always consuming: addresses 0,4,8,...
    imem_ready = 1'b1; mem_lat = 0; PC_write = 1'b1;
    repeat (6) cycle();
    check("zw_addr", imem_addr, 32'd12);

    // Stall with a response in flight: held for several cycles, then consumed once.
    PC_write = 1'b0;
    repeat (5) cycle();
    check("hold_pc_if", PC_IF, 32'd12);
    check("hold_instr", INSTRUCTION_IF, mem_word(32'd12));
    PC_write = 1'b1;
    cycle();
    check("hold_adv", imem_addr, 32'd16);

    // Redirect while waiting; stale response arrives later and is discarded.
    mem_lat = 2;
    cycle();                                   // request accepted
    PCSrc = 1'b1; PC_Branch = 32'h0000_0103;
    cycle();
    PCSrc = 1'b0;
    run_until_req(10);
    check("redir_wait_addr", imem_addr, 32'h0000_0100);

    // Redirect in the same cycle the old request is accepted.
    mem_lat = 0; imem_ready = 1'b1;
    PCSrc = 1'b1; PC_Branch = 32'h0000_0200;
    cycle();
    PCSrc = 1'b0;
    run_until_req(10);
    check("redir_acc_addr", imem_addr, 32'h0000_0200);

    // PC wrap: redirect to the last word with the request held off.
    imem_ready = 1'b0; PCSrc = 1'b1; PC_Branch = 32'hFFFF_FFFE;
    cycle();
    PCSrc = 1'b0;
    check("wrap_start", imem_addr, 32'hFFFF_FFFC);
    imem_ready = 1'b1;
    cycle();
    run_until_req(10);
    check("wrap_addr", imem_addr, 32'h0000_0000);

    // Asynchronous reset in the middle of WAIT.
    mem_lat = 2;
    cycle();                                   // accepted, now waiting
    #2 reset = 1'b1;
    #1;
    check("areset_req",   {31'b0, imem_req}, 32'd1);
    check("areset_addr",  imem_addr, RST_PC);
    check("areset_valid", {31'b0, IF_valid}, 32'd0);
    check("areset_instr", INSTRUCTION_IF, NOP);
    check("areset_pc_if", PC_IF, RST_PC);
    @(negedge clk);
    reset = 1'b0;
    reset_model();
    imem_ready = 1'b0;
    cycle();
    check("post_rst_addr", imem_addr, RST_PC);

    // Randomized traffic against the model.
    rand_lat = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      PC_write   = ($urandom_range(0, 9) < 7);
      imem_ready = ($urandom_range(0, 9) < 6);
      PCSrc      = ($urandom_range(0, 9) == 0);
      PC_Branch  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
                                               : $urandom;
      cycle();
    end

    $display("%0d/%0d checks passed", n_total - n_fail, n_total);
    $finish;
  end

endmodule
